// File: rtl/cmd_parser.sv
// Host command parser: assembles 6-byte headers into MREQs and forwards write payload
// bytes to the executor, rejecting malformed first bytes and timing out stalled headers.
module cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  localparam int unsigned MREQ_NBIT = 45
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx_valid,
  input  logic [7:0]           i_rx_data,
  output logic                 o_rx_ready,
  output logic                 o_mreq_valid,
  input  logic                 i_mreq_ready,
  output logic [MREQ_NBIT-1:0] o_mreq,
  output logic                 o_wdata_valid,
  output logic [7:0]           o_wdata,
  input  logic                 i_wdata_ready,
  output logic                 o_err
);

  // MREQ layout, MSB first: tag[44:37], wr[36], aincr[35], wfmt[34:32], wcnt[31:24], addr[23:0]
  localparam int unsigned MREQ_WR_BIT = 36;
  localparam logic [2:0] MREQ_WFMT_8S0  = 3'd0;
  localparam logic [2:0] MREQ_WFMT_8S3  = 3'd3;
  localparam logic [2:0] MREQ_WFMT_16S0 = 3'd4;
  localparam logic [2:0] MREQ_WFMT_16S1 = 3'd5;
  localparam logic [2:0] MREQ_WFMT_32S0 = 3'd6;

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_MREQ = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]           state, state_nxt;
  logic [2:0]           idx, idx_nxt;
  logic                 hdr_wr, hdr_wr_nxt;
  logic                 hdr_aincr, hdr_aincr_nxt;
  logic [2:0]           hdr_wfmt, hdr_wfmt_nxt;
  logic [7:0]           hdr_tag, hdr_tag_nxt;
  logic [7:0]           hdr_wcnt, hdr_wcnt_nxt;
  logic [7:0]           addr_lo, addr_lo_nxt;
  logic [7:0]           addr_mid, addr_mid_nxt;
  logic [MREQ_NBIT-1:0] mreq_q, mreq_nxt;
  logic                 mreq_valid_q, mreq_valid_nxt;
  logic [9:0]           cnt, cnt_nxt;
  logic [TMO_W-1:0]     tmo, tmo_nxt;
  logic                 err_q, err_nxt;
  logic                 rx_take;
  logic                 b0_ok;
  logic [9:0]           plen_m1;

  // Ready and payload pass-through are combinational so ST_DATA adds no latency
  assign o_rx_ready    = (state == ST_HDR) || ((state == ST_DATA) && i_wdata_ready);
  assign o_wdata_valid = (state == ST_DATA) && i_rx_valid;
  assign o_wdata       = i_rx_data;
  assign o_mreq        = mreq_q;
  assign o_mreq_valid  = mreq_valid_q;
  assign o_err         = err_q;

  assign rx_take = i_rx_valid && o_rx_ready;
  assign b0_ok   = (i_rx_data[5:3] == 3'd0) && (i_rx_data[2:0] != 3'd7);

  // Payload length minus one: (wcnt+1)*bpw - 1, bpw taken from the latched wfmt
  always_comb begin
    plen_m1 = {2'b00, mreq_q[31:24]};
    if (mreq_q[34:32] == MREQ_WFMT_32S0) begin
      plen_m1 = {mreq_q[31:24], 2'b11};
    end else if ((mreq_q[34:32] == MREQ_WFMT_16S0) || (mreq_q[34:32] == MREQ_WFMT_16S1)) begin
      plen_m1 = {1'b0, mreq_q[31:24], 1'b1};
    end else if ((mreq_q[34:32] >= MREQ_WFMT_8S0) && (mreq_q[34:32] <= MREQ_WFMT_8S3)) begin
      plen_m1 = {2'b00, mreq_q[31:24]};
    end
  end

  // Next-state and datapath update for header assembly, MREQ handshake and payload count
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    hdr_wr_nxt     = hdr_wr;
    hdr_aincr_nxt  = hdr_aincr;
    hdr_wfmt_nxt   = hdr_wfmt;
    hdr_tag_nxt    = hdr_tag;
    hdr_wcnt_nxt   = hdr_wcnt;
    addr_lo_nxt    = addr_lo;
    addr_mid_nxt   = addr_mid;
    mreq_nxt       = mreq_q;
    mreq_valid_nxt = mreq_valid_q;
    cnt_nxt        = cnt;
    tmo_nxt        = tmo;
    err_nxt        = 1'b0;
    case (state)
      ST_HDR: begin
        if (rx_take) begin
          tmo_nxt = '0;
          case (idx)
            3'd0: begin
              if (b0_ok) begin
                hdr_wr_nxt    = i_rx_data[7];
                hdr_aincr_nxt = i_rx_data[6];
                hdr_wfmt_nxt  = i_rx_data[2:0];
                idx_nxt       = 3'd1;
              end else begin
                err_nxt = 1'b1;
              end
            end
            3'd1: begin hdr_tag_nxt  = i_rx_data; idx_nxt = 3'd2; end
            3'd2: begin hdr_wcnt_nxt = i_rx_data; idx_nxt = 3'd3; end
            3'd3: begin addr_lo_nxt  = i_rx_data; idx_nxt = 3'd4; end
            3'd4: begin addr_mid_nxt = i_rx_data; idx_nxt = 3'd5; end
            3'd5: begin
              mreq_nxt       = {hdr_tag, hdr_wr, hdr_aincr, hdr_wfmt, hdr_wcnt,
                                i_rx_data, addr_mid, addr_lo};
              mreq_valid_nxt = 1'b1;
              idx_nxt        = 3'd0;
              state_nxt      = ST_MREQ;
            end
            default: idx_nxt = 3'd0;
          endcase
        end else if ((idx != 3'd0) && (TIMEOUT_CYCLES != 0)) begin
          if (tmo == TMO_LAST) begin
            tmo_nxt = '0;
            idx_nxt = 3'd0;
            err_nxt = 1'b1;
          end else begin
            tmo_nxt = tmo + TMO_W'(1);
          end
        end
      end
      ST_MREQ: begin
        if (i_mreq_ready) begin
          mreq_valid_nxt = 1'b0;
          if (mreq_q[MREQ_WR_BIT]) begin
            cnt_nxt   = plen_m1;
            state_nxt = ST_DATA;
          end else begin
            state_nxt = ST_HDR;
          end
        end
      end
      ST_DATA: begin
        if (i_rx_valid && i_wdata_ready) begin
          if (cnt == 10'd0) begin
            idx_nxt   = 3'd0;
            state_nxt = ST_HDR;
          end else begin
            cnt_nxt = cnt - 10'd1;
          end
        end
      end
      default: state_nxt = ST_HDR;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_HDR;
      idx          <= 3'd0;
      hdr_wr       <= 1'b0;
      hdr_aincr    <= 1'b0;
      hdr_wfmt     <= 3'd0;
      hdr_tag      <= 8'd0;
      hdr_wcnt     <= 8'd0;
      addr_lo      <= 8'd0;
      addr_mid     <= 8'd0;
      mreq_q       <= '0;
      mreq_valid_q <= 1'b0;
      cnt          <= 10'd0;
      tmo          <= '0;
      err_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      hdr_wr       <= hdr_wr_nxt;
      hdr_aincr    <= hdr_aincr_nxt;
      hdr_wfmt     <= hdr_wfmt_nxt;
      hdr_tag      <= hdr_tag_nxt;
      hdr_wcnt     <= hdr_wcnt_nxt;
      addr_lo      <= addr_lo_nxt;
      addr_mid     <= addr_mid_nxt;
      mreq_q       <= mreq_nxt;
      mreq_valid_q <= mreq_valid_nxt;
      cnt          <= cnt_nxt;
      tmo          <= tmo_nxt;
      err_q        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_cmd_parser.sv
// Scoreboard bench for cmd_parser: expected MREQs and payload bytes are queued as
// stimulus is driven and checked by a negedge monitor when the DUT hands them off.
`timescale 1ns/1ps
module tb_cmd_parser;

  localparam int unsigned MREQ_NBIT = 45;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 rx_valid;
  logic [7:0]           rx_data;
  logic                 rx_ready;
  logic                 mreq_valid;
  logic                 mreq_ready;
  logic [MREQ_NBIT-1:0] mreq;
  logic                 wdata_valid;
  logic [7:0]           wdata;
  logic                 wdata_ready;
  logic                 err;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  bit tog_en  = 1'b0;

  logic [MREQ_NBIT-1:0] exp_mreq_q[$];
  logic [7:0]           exp_wdata_q[$];

  cmd_parser #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_rx_valid(rx_valid), .i_rx_data(rx_data), .o_rx_ready(rx_ready),
    .o_mreq_valid(mreq_valid), .i_mreq_ready(mreq_ready), .o_mreq(mreq),
    .o_wdata_valid(wdata_valid), .o_wdata(wdata), .i_wdata_ready(wdata_ready),
    .o_err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [MREQ_NBIT-1:0] pack(input logic [7:0] tag, input logic wr,
      input logic aincr, input logic [2:0] wfmt, input logic [7:0] wcnt, input logic [23:0] addr);
    return {tag, wr, aincr, wfmt, wcnt, addr};
  endfunction

  // Executor-side ready jitter during payload phases
  always @(posedge clk) begin
    #1;
    if (tog_en) wdata_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops scoreboard on handshakes, checks MREQ stability and err pulse width
  logic [MREQ_NBIT-1:0] held;
  bit held_v = 1'b0;
  bit err_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      held_v   = 1'b0;
      err_prev = 1'b0;
    end else begin
      if (mreq_valid) begin
        if (held_v) begin
          n_tests++;
          if (mreq !== held) begin
            n_fail++;
            $display("FAIL mreq_stable got=%h held=%h", mreq, held);
          end
        end
        if (mreq_ready) begin
          n_tests++;
          if (exp_mreq_q.size() == 0) begin
            n_fail++;
            $display("FAIL mreq_unexpected got=%h", mreq);
          end else begin
            logic [MREQ_NBIT-1:0] e;
            e = exp_mreq_q.pop_front();
            if (mreq !== e) begin
              n_fail++;
              $display("FAIL mreq_value got=%h exp=%h", mreq, e);
            end
          end
          held_v = 1'b0;
        end else begin
          held   = mreq;
          held_v = 1'b1;
        end
      end else begin
        held_v = 1'b0;
      end
      if (wdata_valid) begin
        n_tests++;
        if (rx_ready !== wdata_ready) begin
          n_fail++;
          $display("FAIL rx_ready_track got=%b exp=%b", rx_ready, wdata_ready);
        end
        if (wdata_ready) begin
          n_tests++;
          if (exp_wdata_q.size() == 0) begin
            n_fail++;
            $display("FAIL wdata_unexpected got=%h", wdata);
          end else begin
            logic [7:0] w;
            w = exp_wdata_q.pop_front();
            if (wdata !== w) begin
              n_fail++;
              $display("FAIL wdata_value got=%h exp=%h", wdata, w);
            end
          end
        end
      end
      if (err) begin
        err_cnt++;
        n_tests++;
        if (err_prev) begin
          n_fail++;
          $display("FAIL err_width got=2+ cycles exp=1");
        end
      end
      err_prev = err;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    int n;
    rx_valid = 1'b0;
    if (gap > 0) cycles(gap);
    rx_valid = 1'b1;
    rx_data  = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk); #1;
      n++;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout byte=%h not accepted in %0d cycles", b, n);
    end
  endtask

  task automatic send_hdr(input logic [7:0] b0, input logic [7:0] tag,
                          input logic [7:0] wcnt, input logic [23:0] addr);
    exp_mreq_q.push_back(pack(tag, b0[7], b0[6], b0[2:0], wcnt, addr));
    send_byte(b0, 0);
    send_byte(tag, 0);
    send_byte(wcnt, 0);
    send_byte(addr[7:0], 0);
    send_byte(addr[15:8], 0);
    send_byte(addr[23:16], 0);
  endtask

  task automatic check_drained(input string name);
    cycles(3);
    n_tests++;
    if (exp_mreq_q.size() != 0 || exp_wdata_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain got mreq_left=%0d wdata_left=%0d exp=0,0",
               name, exp_mreq_q.size(), exp_wdata_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_tests++;
    if (mreq_valid !== 1'b0 || wdata_valid !== 1'b0 || err !== 1'b0 ||
        rx_ready !== 1'b1 || mreq !== '0) begin
      n_fail++;
      $display("FAIL %s got mv=%b wv=%b err=%b rdy=%b mreq=%h exp 0,0,0,1,0",
               name, mreq_valid, wdata_valid, err, rx_ready, mreq);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; mreq_ready = 1'b1; wdata_ready = 1'b1;
    cycles(2);
    check_reset_outputs("reset_values");
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic test_read();
    exp_mreq_q.push_back(pack(8'h5A, 1'b0, 1'b0, 3'd3, 8'h00, 24'h302010));
    mreq_ready = 1'b0;
    send_byte(8'h03, 0); send_byte(8'h5A, 0); send_byte(8'h00, 0);
    send_byte(8'h10, 0); send_byte(8'h20, 0); send_byte(8'h30, 0);
    n_tests++;
    if (mreq_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL read_latency got mreq_valid=%b exp=1", mreq_valid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (rx_ready !== 1'b0 || mreq_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL read_hold got rdy=%b mv=%b exp rdy=0 mv=1", rx_ready, mreq_valid);
      end
      @(posedge clk); #1;
    end
    mreq_ready = 1'b1;
    cycles(2);
    n_tests++;
    if (mreq_valid !== 1'b0 || rx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL read_release got mv=%b rdy=%b exp mv=0 rdy=1", mreq_valid, rx_ready);
    end
    check_drained("read");
  endtask

  task automatic test_write();
    mreq_ready = 1'b1;
    send_hdr(8'h86, 8'h77, 8'h01, 24'hABCDEF);
    for (int i = 1; i <= 8; i++) exp_wdata_q.push_back(8'(i * 8'h11));
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11), 0);
    send_hdr(8'h01, 8'hA5, 8'h07, 24'h000042);
    check_drained("write");
  endtask

  task automatic test_back_to_back_backpressure();
    logic [7:0] b;
    mreq_ready = 1'b0;
    send_hdr(8'hC4, 8'h3C, 8'h03, 24'h000100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (rx_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready got=%b exp=0 cycle=%0d", rx_ready, i);
      end
      @(posedge clk); #1;
    end
    tog_en = 1'b1;
    mreq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_wdata_q.push_back(b);
      send_byte(b, int'($urandom_range(0, 2)));
    end
    tog_en = 1'b0;
    wdata_ready = 1'b1;
    send_hdr(8'h02, 8'h5F, 8'h00, 24'h123456);
    check_drained("backpressure");
  endtask

  task automatic test_bad_b0();
    int e0;
    e0 = err_cnt;
    send_byte(8'h38, 0);
    cycles(2);
    send_byte(8'h07, 0);
    cycles(2);
    send_hdr(8'h40, 8'h11, 8'hFF, 24'h010203);
    check_drained("bad_b0");
    n_tests++;
    if (err_cnt != e0 + 2) begin
      n_fail++;
      $display("FAIL bad_b0_err got=%0d exp=%0d", err_cnt - e0, 2);
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    send_byte(8'h03, 0);
    send_byte(8'h99, 0);
    cycles(15);
    n_tests++;
    if (err_cnt != e0) begin
      n_fail++;
      $display("FAIL timeout_early got=%0d exp=0", err_cnt - e0);
    end
    cycles(3);
    n_tests++;
    if (err_cnt != e0 + 1) begin
      n_fail++;
      $display("FAIL timeout_fire got=%0d exp=1", err_cnt - e0);
    end
    send_hdr(8'h00, 8'h21, 8'h00, 24'hC0FFEE);
    check_drained("timeout_resync");
    e0 = err_cnt;
    exp_mreq_q.push_back(pack(8'h99, 1'b0, 1'b0, 3'd3, 8'h04, 24'h030201));
    send_byte(8'h03, 0);
    send_byte(8'h99, 0);
    cycles(15);
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    check_drained("timeout_edge");
    n_tests++;
    if (err_cnt != e0) begin
      n_fail++;
      $display("FAIL timeout_edge_err got=%0d exp=0", err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_payload();
    send_hdr(8'h85, 8'h44, 8'h01, 24'h00ABCD);
    exp_wdata_q.push_back(8'hD1);
    exp_wdata_q.push_back(8'hD2);
    send_byte(8'hD1, 0);
    send_byte(8'hD2, 0);
    rst = 1'b1;
    cycles(1);
    check_reset_outputs("reset_mid_payload");
    rst = 1'b0;
    n_tests++;
    if (exp_wdata_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_prior_bytes got left=%0d exp=0", exp_wdata_q.size());
    end
    exp_mreq_q.delete();
    exp_wdata_q.delete();
    send_hdr(8'h03, 8'h66, 8'h00, 24'h7F7F7F);
    check_drained("reset_fresh");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=no finish exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back_backpressure();
    test_bad_b0();
    test_timeout();
    test_reset_mid_payload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
